// File: rtl/plot_receiver.sv
// Pixel-plot receiver: range-checks plot requests, queues them in a small FIFO
// and retires them as single-word framebuffer writes, yielding to scan-out.
//
//   state     | meaning
//   ----------+----------------------------------------------------------
//   ST_IDLE   | no write on the RAM port this cycle
//   ST_WRITE  | fbWren high with the entry popped on the previous edge
module plot_receiver #(
   parameter int WIDTH      = 160,
   parameter int HEIGHT     = 120,
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [7:0]  iX,
   input  logic [6:0]  iY,
   input  logic [8:0]  iColour,
   input  logic        iPlot,
   output logic        oReady,
   input  logic        scanReq,
   output logic        fbWren,
   output logic [14:0] fbAddress,
   output logic [8:0]  fbData,
   output logic [7:0]  oDropCount,
   output logic [15:0] oPixelCount,
   output logic        oIdle
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic {ST_IDLE, ST_WRITE} state_t;

   typedef struct packed {
      logic [14:0] addr;
      logic [8:0]  colour;
   } entry_t;

   state_t        state_q, state_d;
   entry_t        mem_q [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          fb_wren_q, fb_wren_d;
   logic [14:0]   fb_addr_q, fb_addr_d;
   logic [8:0]    fb_data_q, fb_data_d;
   logic [7:0]    drop_q, drop_d;
   logic [15:0]   pix_q, pix_d;

   logic          in_range;
   logic [14:0]   plot_addr;
   logic          fire;
   logic          push;
   logic          drop;
   logic          pop;
   entry_t        head;

   // Row stride of 160 built as 128 + 32 so no multiplier is needed.
   always_comb begin
      in_range  = (32'(iX) < WIDTH) && (32'(iY) < HEIGHT);
      plot_addr = (15'(iY) << 7) + (15'(iY) << 5) + 15'(iX);
      oReady    = (cnt_q != CW'(FIFO_DEPTH));
      fire      = iPlot & oReady;
      push      = fire & in_range;
      drop      = fire & ~in_range;
      pop       = (cnt_q != '0) & ~scanReq;
      head      = mem_q[rd_ptr_q];
      oIdle     = (cnt_q == '0) && (state_q == ST_IDLE);
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end
      cnt_d = cnt_q + CW'(push) - CW'(pop);
   end

   always_comb begin
      state_d   = state_q;
      fb_wren_d = 1'b0;
      fb_addr_d = fb_addr_q;
      fb_data_d = fb_data_q;
      case (state_q)
         ST_IDLE: begin
            if (pop) begin
               state_d = ST_WRITE;
            end
         end
         ST_WRITE: begin
            if (!pop) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (pop) begin
         fb_wren_d = 1'b1;
         fb_addr_d = head.addr;
         fb_data_d = head.colour;
      end
   end

   // A write counts as complete on the edge that ends its WRITE cycle.
   always_comb begin
      drop_d = drop_q;
      if (drop && (drop_q != 8'hFF)) begin
         drop_d = drop_q + 8'd1;
      end
      pix_d = pix_q;
      if (state_q == ST_WRITE) begin
         pix_d = pix_q + 16'd1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         cnt_q     <= '0;
         fb_wren_q <= 1'b0;
         fb_addr_q <= '0;
         fb_data_q <= '0;
         drop_q    <= '0;
         pix_q     <= '0;
      end else begin
         state_q   <= state_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         cnt_q     <= cnt_d;
         fb_wren_q <= fb_wren_d;
         fb_addr_q <= fb_addr_d;
         fb_data_q <= fb_data_d;
         drop_q    <= drop_d;
         pix_q     <= pix_d;
      end
   end

   always_ff @(posedge clock) begin
      if (push) begin
         mem_q[wr_ptr_q] <= '{addr: plot_addr, colour: iColour};
      end
   end

   assign fbWren      = fb_wren_q;
   assign fbAddress   = fb_addr_q;
   assign fbData      = fb_data_q;
   assign oDropCount  = drop_q;
   assign oPixelCount = pix_q;

endmodule

// File: tb/tb_plot_receiver.sv
// Directed and randomized bench for plot_receiver against a queue-based
// model of accepted pixels, dropped requests and completed writes.
module tb_plot_receiver;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  iX;
   logic [6:0]  iY;
   logic [8:0]  iColour;
   logic        iPlot;
   logic        oReady;
   logic        scanReq;
   logic        fbWren;
   logic [14:0] fbAddress;
   logic [8:0]  fbData;
   logic [7:0]  oDropCount;
   logic [15:0] oPixelCount;
   logic        oIdle;

   typedef struct {
      int addr;
      int colour;
   } pix_t;

   pix_t exp_q[$];
   int   n_vec = 0;
   int   n_err = 0;
   int   drop_model = 0;
   int   px_model = 0;
   int   scan_mode = 0;
   logic scan_man = 1'b0;
   logic scan_tog = 1'b0;
   logic last_scan = 1'b0;

   assign scanReq = (scan_mode == 0) ? scan_man : scan_tog;

   always #5 clk = ~clk;

   plot_receiver dut (
      .clock(clk), .reset(reset), .iX(iX), .iY(iY), .iColour(iColour),
      .iPlot(iPlot), .oReady(oReady), .scanReq(scanReq), .fbWren(fbWren),
      .fbAddress(fbAddress), .fbData(fbData), .oDropCount(oDropCount),
      .oPixelCount(oPixelCount), .oIdle(oIdle)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int drop_exp();
      return (drop_model > 255) ? 255 : drop_model;
   endfunction

   // Producer: hold the request until the receiver is ready, then record it.
   task automatic plot(input int x, input int y, input int c);
      bit done = 0;
      bit rdy;
      iX = 8'(x); iY = 7'(y); iColour = 9'(c); iPlot = 1'b1;
      for (int t = 0; t < 300 && !done; t++) begin
         rdy = oReady;
         @(posedge clk);
         if (rdy) begin
            done = 1;
            if (x < 160 && y < 120) exp_q.push_back('{x + 160 * y, c});
            else drop_model++;
         end
         @(negedge clk);
      end
      iPlot = 1'b0;
      if (!done) chk("plot_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_idle();
      for (int t = 0; t < 3000; t++) begin
         @(negedge clk);
         if (oIdle && exp_q.size() == 0) break;
      end
      chk("idle", 32'(oIdle), 32'd1);
      chk("queue_drained", exp_q.size(), 32'd0);
      chk("pixel_count", 32'(oPixelCount), 32'(16'(px_model)));
      chk("drop_count", 32'(oDropCount), drop_exp());
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      iPlot = 1'b0;
      @(posedge clk);
      exp_q.delete();
      px_model = 0;
      drop_model = 0;
      @(negedge clk);
      reset = 1'b0;
      chk("rst_wren", 32'(fbWren), 32'd0);
      chk("rst_addr", 32'(fbAddress), 32'd0);
      chk("rst_data", 32'(fbData), 32'd0);
      chk("rst_drop", 32'(oDropCount), 32'd0);
      chk("rst_pix", 32'(oPixelCount), 32'd0);
      chk("rst_ready", 32'(oReady), 32'd1);
      chk("rst_idle", 32'(oIdle), 32'd1);
   endtask

   task automatic monitor();
      pix_t e;
      forever begin
         @(posedge clk);
         last_scan = scanReq;
         @(negedge clk);
         if (fbWren) begin
            n_vec++;
            assert (exp_q.size() != 0) else begin
               n_err++;
               $error("FAIL spurious_write: observed addr %0d expected no write", fbAddress);
            end
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               chk("wr_addr", 32'(fbAddress), e.addr);
               chk("wr_data", 32'(fbData), e.colour);
            end
            chk("wr_scan_low", 32'(last_scan), 32'd0);
            px_model++;
         end
      end
   endtask

   task automatic scan_driver();
      forever begin
         @(negedge clk);
         if (scan_mode == 1) scan_tog = ~scan_tog;
         else scan_tog = 1'($urandom_range(0, 1));
      end
   endtask

   initial begin
      reset = 1'b1; iX = '0; iY = '0; iColour = '0; iPlot = 1'b0;
      fork
         monitor();
         scan_driver();
      join_none
      do_reset();

      // single plot: latency and content
      plot(5, 3, 9'h1FF);
      chk("lat_edge1", 32'(fbWren), 32'd0);
      @(negedge clk);
      chk("lat_edge2_wren", 32'(fbWren), 32'd1);
      chk("lat_addr", 32'(fbAddress), 32'd485);
      chk("lat_data", 32'(fbData), 32'h1FF);
      @(negedge clk);
      chk("lat_one_cycle", 32'(fbWren), 32'd0);
      chk("single_pix", 32'(oPixelCount), 32'd1);
      chk("single_idle", 32'(oIdle), 32'd1);

      // corners and out-of-range
      plot(159, 119, 9'h0A5);
      plot(0, 0, 9'h15A);
      plot(160, 0, 9'h001);
      plot(0, 120, 9'h002);
      wait_idle();
      chk("corner_drops", 32'(oDropCount), 32'd2);

      // scan-out holds the port: FIFO fills, producer stalls
      scan_man = 1'b1;
      for (int i = 0; i < 4; i++) plot(10 + i, 20, 9'h100 + i);
      iX = 8'd50; iY = 7'd60; iColour = 9'h044; iPlot = 1'b1;
      chk("full_ready_low", 32'(oReady), 32'd0);
      @(negedge clk);
      chk("full_ready_hold", 32'(oReady), 32'd0);
      chk("full_no_write", 32'(fbWren), 32'd0);
      iPlot = 1'b0;
      scan_man = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("b2b_write", 32'(fbWren), 32'd1);
      end
      @(negedge clk);
      chk("b2b_end", 32'(fbWren), 32'd0);
      chk("b2b_ready", 32'(oReady), 32'd1);
      plot(50, 60, 9'h044);
      plot(51, 60, 9'h055);
      wait_idle();

      // scanReq toggling every cycle with a full FIFO
      scan_man = 1'b1;
      for (int i = 0; i < 4; i++) plot(i, 100, 9'h0F0 + i);
      scan_mode = 1;
      for (int i = 0; i < 8; i++)
         plot($urandom_range(0, 159), $urandom_range(0, 119), $urandom_range(0, 511));
      wait_idle();
      scan_mode = 0;
      scan_man = 1'b0;

      // reset with three entries queued
      scan_man = 1'b1;
      for (int i = 0; i < 3; i++) plot(70 + i, 7, 9'h111);
      scan_man = 1'b0;
      do_reset();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("post_rst_no_write", 32'(fbWren), 32'd0);
      end
      chk("post_rst_idle", 32'(oIdle), 32'd1);

      // randomized traffic with random scan-out contention
      scan_mode = 2;
      for (int i = 0; i < 200; i++)
         plot($urandom_range(0, 175), $urandom_range(0, 127), $urandom_range(0, 511));
      wait_idle();
      scan_mode = 0;

      // drop counter saturation
      for (int i = 0; i < 300; i++)
         plot($urandom_range(160, 255), $urandom_range(0, 127), $urandom_range(0, 511));
      wait_idle();
      chk("drop_saturated", 32'(oDropCount), 32'd255);

      // pixel counter wrap
      do_reset();
      for (int i = 0; i < 65536; i++)
         plot($urandom_range(0, 159), $urandom_range(0, 119), $urandom_range(0, 511));
      wait_idle();
      chk("pixel_wrap", 32'(oPixelCount), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
